// File: rtl/sc_gamecontrol.sv
// Frogger game-level controller: round sequencing, lose/win pulses, lives/level and car-lane tick.
// Optional bonus life on each win when SC_GAMECONTROL_BONUSLIFE_EN is defined.
module sc_gamecontrol #(
  parameter int LIVES_INIT = 3,
  parameter int TICK_WIDTH = 26,
  parameter int TICK_BASE  = 25000000,
  parameter int TICK_STEP  = 2500000
) (
  input  logic       SC_GAMECONTROL_CLOCK_50,
  input  logic       SC_GAMECONTROL_RESET_InHigh,
  input  logic       SC_GAMECONTROL_startButton_InLow,
  input  logic       SC_GAMECONTROL_collision_InHigh,
  input  logic       SC_GAMECONTROL_topReached_InHigh,
  output logic       SC_GAMECONTROL_lose_OutHigh,
  output logic       SC_GAMECONTROL_win_OutHigh,
  output logic       SC_GAMECONTROL_carTick_OutHigh,
  output logic [1:0] SC_GAMECONTROL_lives_Out,
  output logic [2:0] SC_GAMECONTROL_level_Out,
  output logic       SC_GAMECONTROL_gameOver_OutHigh,
  output logic [2:0] SC_GAMECONTROL_state_Out
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_LOSE = 3'd2,
    ST_WIN  = 3'd3,
    ST_HOLD = 3'd4,
    ST_OVER = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              lives_q, lives_d;
  logic [2:0]              level_q, level_d;
  logic [TICK_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    btn_q, btn_d;

  logic                    start_press;
  logic [TICK_WIDTH-1:0]   period;
  logic [TICK_WIDTH-1:0]   period_m1;

  assign start_press = btn_q & ~SC_GAMECONTROL_startButton_InLow;
  assign period      = TICK_WIDTH'(TICK_BASE) - TICK_WIDTH'(level_q) * TICK_WIDTH'(TICK_STEP);
  assign period_m1   = period - TICK_WIDTH'(1);

  always_ff @(posedge SC_GAMECONTROL_CLOCK_50 or posedge SC_GAMECONTROL_RESET_InHigh) begin
    if (SC_GAMECONTROL_RESET_InHigh) begin
      state_q <= ST_IDLE;
      lives_q <= 2'(LIVES_INIT);
      level_q <= 3'd0;
      cnt_q   <= '0;
      btn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    btn_d   = SC_GAMECONTROL_startButton_InLow;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_press) begin
          lives_d = 2'(LIVES_INIT);
          level_d = 3'd0;
          cnt_d   = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // ">=" also covers a level-up that shrank the period below the count.
        if (cnt_q >= period_m1) cnt_d = '0;
        else                    cnt_d = cnt_q + TICK_WIDTH'(1);
        if (SC_GAMECONTROL_collision_InHigh)       state_d = ST_LOSE;
        else if (SC_GAMECONTROL_topReached_InHigh) state_d = ST_WIN;
      end
      ST_LOSE: begin
        lives_d = lives_q - 2'd1;
        state_d = (lives_q == 2'd1) ? ST_OVER : ST_HOLD;
      end
      ST_WIN: begin
        if (level_q != 3'd7) level_d = level_q + 3'd1;
`ifdef SC_GAMECONTROL_BONUSLIFE_EN
        if (lives_q < 2'd3) lives_d = lives_q + 2'd1;
`endif
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Wait for the frog to clear both triggers before re-arming.
        if (!SC_GAMECONTROL_collision_InHigh && !SC_GAMECONTROL_topReached_InHigh)
          state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign SC_GAMECONTROL_lose_OutHigh     = (state_q == ST_LOSE);
  assign SC_GAMECONTROL_win_OutHigh      = (state_q == ST_WIN);
  assign SC_GAMECONTROL_gameOver_OutHigh = (state_q == ST_OVER);
  assign SC_GAMECONTROL_carTick_OutHigh  = (state_q == ST_PLAY) && (cnt_q == period_m1);
  assign SC_GAMECONTROL_lives_Out        = lives_q;
  assign SC_GAMECONTROL_level_Out        = level_q;
  assign SC_GAMECONTROL_state_Out        = state_q;

endmodule

// File: tb/tb_sc_gamecontrol.sv
// Directed bench for sc_gamecontrol with TICK_BASE=10, TICK_STEP=1, LIVES_INIT=3.
module tb_sc_gamecontrol;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_n;
  logic       col;
  logic       top;
  logic       lose;
  logic       win;
  logic       car_tick;
  logic [1:0] lives;
  logic [2:0] level;
  logic       game_over;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sc_gamecontrol #(
    .LIVES_INIT(3),
    .TICK_WIDTH(26),
    .TICK_BASE (10),
    .TICK_STEP (1)
  ) dut (
    .SC_GAMECONTROL_CLOCK_50          (clk),
    .SC_GAMECONTROL_RESET_InHigh      (rst),
    .SC_GAMECONTROL_startButton_InLow (start_n),
    .SC_GAMECONTROL_collision_InHigh  (col),
    .SC_GAMECONTROL_topReached_InHigh (top),
    .SC_GAMECONTROL_lose_OutHigh      (lose),
    .SC_GAMECONTROL_win_OutHigh       (win),
    .SC_GAMECONTROL_carTick_OutHigh   (car_tick),
    .SC_GAMECONTROL_lives_Out         (lives),
    .SC_GAMECONTROL_level_Out         (level),
    .SC_GAMECONTROL_gameOver_OutHigh  (game_over),
    .SC_GAMECONTROL_state_Out         (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until carTick is seen high, bounded; 99 marks an expired bound.
  task automatic next_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!car_tick && n < 60);
    if (!car_tick) n = 99;
  endtask

  // Holds collision for n cycles, counting lose pulses, then releases it for one edge.
  task automatic collide(input int n, output int pulses, output int st_held);
    pulses = 0;
    col = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (lose) pulses++;
    end
    st_held = int'(state);
    col = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int pulses;
    int st_held;
    int quiet;
    int exp_lives;

    rst = 1'b1; start_n = 1'b1; col = 1'b0; top = 1'b0;
    #23;
    check("reset_state", state, 0);
    check("reset_lives", lives, 3);
    check("reset_level", level, 0);
    check("reset_pulses", {lose, win, car_tick, game_over}, 0);
    rst = 1'b0;
    step();
    check("idle_wait", state, 0);

    // Start press: PLAY with counter 0, tick on the 10th PLAY cycle then every 10.
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    check("start_state", state, 1);
    check("start_lives", lives, 3);
    check("start_level", level, 0);
    check("start_tick_low", car_tick, 0);
    next_tick(n);
    check("first_tick_edges", n, 9);
    next_tick(n);
    check("tick_period_l0", n, 10);
    next_tick(n);
    check("tick_period_l0_again", n, 10);

    // Loss with collision held for 5 cycles.
    collide(5, pulses, st_held);
    check("loss1_pulses", pulses, 1);
    check("loss1_hold", st_held, 4);
    check("loss1_lives", lives, 2);
    check("loss1_play", state, 1);
    collide(5, pulses, st_held);
    check("loss2_pulses", pulses, 1);
    check("loss2_lives", lives, 1);
    check("loss2_play", state, 1);
    collide(5, pulses, st_held);
    check("loss3_pulses", pulses, 1);
    check("over_state", state, 5);
    check("over_flag", game_over, 1);
    check("over_lives", lives, 0);
    quiet = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (car_tick) quiet++;
    end
    check("over_no_tick", quiet, 0);
    check("over_stays", state, 5);

    // Restart from OVER with start held low for several cycles.
    start_n = 1'b0;
    step();
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);
    check("restart_level", level, 0);
    for (int i = 0; i < 5; i++) step();
    start_n = 1'b1;
    check("restart_held_state", state, 1);
    check("restart_held_lives", lives, 3);
    next_tick(n);
    check("restart_counter_once", n, 4);

    // Priority: collision and topReached together give a loss only.
    col = 1'b1; top = 1'b1;
    step();
    check("prio_state", state, 2);
    check("prio_lose", lose, 1);
    check("prio_win", win, 0);
    step();
    col = 1'b0; top = 1'b0;
    check("prio_lives", lives, 2);
    check("prio_level", level, 0);
    check("prio_hold", state, 4);
    step();
    check("prio_play", state, 1);

    // Eight wins: level saturates at 7; bonus life only when the macro is on.
    exp_lives = 2;
    for (int w = 1; w <= 8; w++) begin
      top = 1'b1;
      step();
      check($sformatf("win%0d_pulse", w), win, 1);
      check($sformatf("win%0d_nolose", w), lose, 0);
      top = 1'b0;
      step();
`ifdef SC_GAMECONTROL_BONUSLIFE_EN
      exp_lives = 3;
`endif
      check($sformatf("win%0d_level", w), level, (w > 7) ? 7 : w);
      check($sformatf("win%0d_lives", w), lives, exp_lives);
      check($sformatf("win%0d_pulse_end", w), win, 0);
      step();
      check($sformatf("win%0d_play", w), state, 1);
    end
    next_tick(n);
    next_tick(n);
    check("tick_period_l7", n, 3);
    next_tick(n);
    check("tick_period_l7_again", n, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
